// File: rtl/mux_n_reg.sv
// N-channel registered multiplexer with valid/ready flow control, explicit or round-robin select.
// Optional feature macro: MUX_N_REG_TAG_EN adds Dalja_tag (source channel of the held word).
module mux_n_reg #(
    parameter int WIDTH = 24,
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [N*WIDTH-1:0] Hyrja,
    input  logic [N-1:0]       Hyrja_valid,
    output logic [N-1:0]       Hyrja_ready,
    input  logic [SEL_W-1:0]   Zgjedhja,
    input  logic               Modi,
    output logic [WIDTH-1:0]   Dalja,
    output logic               Dalja_valid,
`ifdef MUX_N_REG_TAG_EN
    output logic [SEL_W-1:0]   Dalja_tag,
`endif
    input  logic               Dalja_ready
);

    logic [WIDTH-1:0] r_data_p0;
    logic             r_vld_p0;
    logic [SEL_W-1:0] r_rr_ptr;
`ifdef MUX_N_REG_TAG_EN
    logic [SEL_W-1:0] r_tag_p0;
`endif

    logic             w_can_load;
    logic             w_gnt_vld;
    logic [SEL_W-1:0] w_grant;
    logic [WIDTH-1:0] w_data;
    logic             w_load;
    logic [SEL_W-1:0] w_rr_next;

    // Grant: explicit index only matches in-range channels; round-robin takes the first valid from rr_ptr.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_grant   = '0;
        if (!Modi) begin
            for (int i = 0; i < N; i++) begin
                if (Zgjedhja == SEL_W'(i) && Hyrja_valid[i]) begin
                    w_gnt_vld = 1'b1;
                    w_grant   = SEL_W'(i);
                end
            end
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                for (int i = 0; i < N; i++) begin
                    if (i == (int'(r_rr_ptr) + k) % N && Hyrja_valid[i]) begin
                        w_gnt_vld = 1'b1;
                        w_grant   = SEL_W'(i);
                    end
                end
            end
        end
    end

    always_comb begin
        w_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant == SEL_W'(i)) begin
                w_data = Hyrja[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_can_load = !r_vld_p0 || Dalja_ready;
    assign w_load     = !Reset && w_can_load && w_gnt_vld;
    assign w_rr_next  = (int'(w_grant) == N - 1) ? '0 : w_grant + 1'b1;

    always_comb begin
        Hyrja_ready = '0;
        for (int i = 0; i < N; i++) begin
            Hyrja_ready[i] = w_load && (w_grant == SEL_W'(i));
        end
    end

    // Output register stage
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_data_p0 <= '0;
            r_vld_p0  <= 1'b0;
            r_rr_ptr  <= '0;
`ifdef MUX_N_REG_TAG_EN
            r_tag_p0  <= '0;
`endif
        end else if (w_load) begin
            r_data_p0 <= w_data;
            r_vld_p0  <= 1'b1;
`ifdef MUX_N_REG_TAG_EN
            r_tag_p0  <= w_grant;
`endif
            if (Modi) begin
                r_rr_ptr <= w_rr_next;
            end
        end else if (Dalja_ready) begin
            r_vld_p0 <= 1'b0;
        end
    end

    assign Dalja       = r_data_p0;
    assign Dalja_valid = r_vld_p0;
`ifdef MUX_N_REG_TAG_EN
    assign Dalja_tag   = r_tag_p0;
`endif

endmodule

// File: tb/tb_mux_n_reg.sv
// Scoreboard bench for mux_n_reg: a 4-channel instance for the main paths and a 3-channel one for out-of-range select.
module tb_mux_n_reg;

    logic         clk = 1'b0;
    logic         rst;
    logic [95:0]  hyrja;
    logic [3:0]   hv;
    logic [3:0]   hr;
    logic [1:0]   zgj;
    logic         modi;
    logic [23:0]  dalja;
    logic         dv;
    logic         dr;
`ifdef MUX_N_REG_TAG_EN
    logic [1:0]   dtag;
`endif

    logic [71:0]  hyrja3;
    logic [2:0]   hv3;
    logic [2:0]   hr3;
    logic [1:0]   zgj3;
    logic [23:0]  dalja3;
    logic         dv3;
`ifdef MUX_N_REG_TAG_EN
    logic [1:0]   dtag3;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [25:0] sb_q[$];

    always #5 clk = ~clk;

    mux_n_reg #(.WIDTH(24), .N(4), .SEL_W(2)) u_dut (
        .Clock(clk), .Reset(rst), .Hyrja(hyrja), .Hyrja_valid(hv), .Hyrja_ready(hr),
        .Zgjedhja(zgj), .Modi(modi), .Dalja(dalja), .Dalja_valid(dv),
`ifdef MUX_N_REG_TAG_EN
        .Dalja_tag(dtag),
`endif
        .Dalja_ready(dr)
    );

    mux_n_reg #(.WIDTH(24), .N(3), .SEL_W(2)) u_dut3 (
        .Clock(clk), .Reset(rst), .Hyrja(hyrja3), .Hyrja_valid(hv3), .Hyrja_ready(hr3),
        .Zgjedhja(zgj3), .Modi(1'b0), .Dalja(dalja3), .Dalja_valid(dv3),
`ifdef MUX_N_REG_TAG_EN
        .Dalja_tag(dtag3),
`endif
        .Dalja_ready(1'b1)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [23:0] chdata(input int ch);
        return hyrja[ch*24 +: 24];
    endfunction

    // One cycle: check ready, push expected word if a transfer is due, then compare after the edge.
    task automatic step(input string tag, input logic [3:0] exp_rdy, input bit push, input int ch);
        logic [25:0] e;
        #1;
        check({tag, "_ready"}, {28'd0, hr}, {28'd0, exp_rdy});
        if (push) sb_q.push_back({2'(ch), chdata(ch)});
        @(posedge clk); #1;
        if (push) begin
            e = sb_q.pop_front();
            check({tag, "_data"}, {8'd0, dalja}, {8'd0, e[23:0]});
            check({tag, "_valid"}, {31'd0, dv}, 32'd1);
`ifdef MUX_N_REG_TAG_EN
            check({tag, "_tag"}, {30'd0, dtag}, {30'd0, e[25:24]});
`endif
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst   = 1'b1;
        hv    = 4'b1111;
        modi  = 1'b0;
        zgj   = 2'd0;
        dr    = 1'b1;
        hyrja = {24'h333333, 24'h222222, 24'h111111, 24'h000000};
        hyrja[0 +: 24] = 24'h0A0A0A;
        hyrja3 = {24'h300003, 24'h200002, 24'h100001};
        hv3   = 3'b111;
        zgj3  = 2'd3;

        // reset with all channels valid
        @(posedge clk); #1;
        for (int c = 0; c < 2; c++) begin
            check("rst_ready", {28'd0, hr}, 32'd0);
            check("rst_valid", {31'd0, dv}, 32'd0);
            check("rst_data", {8'd0, dalja}, 32'd0);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        step("first_grant", 4'b0001, 1'b1, 0);

        // explicit select
        hyrja[48 +: 24] = 24'hABCDEF;
        zgj = 2'd2;
        step("explicit", 4'b0100, 1'b1, 2);
        hv = 4'b0000;
        step("drain", 4'b0000, 1'b0, 0);
        check("drain_valid", {31'd0, dv}, 32'd0);
        check("drain_hold", {8'd0, dalja}, 32'h00ABCDEF);
        zgj = 2'd1; hv = 4'b1101;
        step("sel_invalid", 4'b0000, 1'b0, 0);
        check("sel_invalid_valid", {31'd0, dv}, 32'd0);

        // round-robin over all channels, pointer wraps 3 -> 0
        modi = 1'b1; hv = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            step($sformatf("rr%0d", k), 4'(1 << (k % 4)), 1'b1, k % 4);
        end

        // round-robin skips idle channels
        hv = 4'b1010;
        step("rr_skip0", 4'b0010, 1'b1, 1);
        step("rr_skip1", 4'b1000, 1'b1, 3);
        step("rr_skip2", 4'b0010, 1'b1, 1);

        // explicit mode leaves pointer (now 2) untouched
        modi = 1'b0; zgj = 2'd0; hv = 4'b1111;
        step("explicit_mid", 4'b0001, 1'b1, 0);
        modi = 1'b1;
        step("rr_resume", 4'b0100, 1'b1, 2);

        // back-pressure
        modi = 1'b0; zgj = 2'd3;
        hyrja[72 +: 24] = 24'h000111;
        step("bp_load", 4'b1000, 1'b1, 3);
        dr = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step("bp_stall", 4'b0000, 1'b0, 0);
            check("bp_hold_data", {8'd0, dalja}, 32'h00000111);
            check("bp_hold_valid", {31'd0, dv}, 32'd1);
`ifdef MUX_N_REG_TAG_EN
            check("bp_hold_tag", {30'd0, dtag}, 32'd3);
`endif
        end
        dr = 1'b1; zgj = 2'd1; hv = 4'b0010;
        hyrja[24 +: 24] = 24'h5A5A5A;
        step("bp_release", 4'b0010, 1'b1, 1);

        // reset during a stall
        dr = 1'b0; hv = 4'b1111; modi = 1'b1;
        step("pre_rst_stall", 4'b0000, 1'b0, 0);
        check("pre_rst_valid", {31'd0, dv}, 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_ready", {28'd0, hr}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_data", {8'd0, dalja}, 32'd0);
        check("midrst_valid", {31'd0, dv}, 32'd0);
        dr = 1'b1;
        step("rr_after_rst", 4'b0001, 1'b1, 0);

        // out-of-range explicit select on the 3-channel instance
        check("oor_ready", {29'd0, hr3}, 32'd0);
        check("oor_valid", {31'd0, dv3}, 32'd0);
        zgj3 = 2'd2;
        #1;
        check("n3_ready", {29'd0, hr3}, 32'd4);
        @(posedge clk); #1;
        check("n3_data", {8'd0, dalja3}, 32'h00300003);
        check("n3_valid", {31'd0, dv3}, 32'd1);
`ifdef MUX_N_REG_TAG_EN
        check("n3_tag", {30'd0, dtag3}, 32'd2);
`endif

        check("sb_empty", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
